// File: rtl/thunderbird_seq_if.sv
// Request/lamp bundle between the turn-signal switches and the Thunderbird tail-light sequencer.
// The master drives the three requests; the slave (the sequencer) drives the six lamps.
interface thunderbird_seq_if;
   logic left;
   logic right;
   logic haz;
   logic LC;
   logic LB;
   logic LA;
   logic RA;
   logic RB;
   logic RC;

   modport master (
      output left, right, haz,
      input  LC, LB, LA, RA, RB, RC
   );

   modport slave (
      input  left, right, haz,
      output LC, LB, LA, RA, RB, RC
   );
endinterface

// File: rtl/thunderbird_seq.sv
// Thunderbird tail-light sequencer: prescaled Moore FSM producing the three-lamp sweep.
// Lamps are a pure decode of the state register; inputs are only looked at on prescaler ticks.
module thunderbird_seq #(
   parameter int unsigned TICK_DIV = 4
) (
   input  logic             clk,
   input  logic             reset,
   thunderbird_seq_if.slave bus
);

   localparam int unsigned   CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      L1   = 3'd1,
      L2   = 3'd2,
      L3   = 3'd3,
      R1   = 3'd4,
      R2   = 3'd5,
      R3   = 3'd6,
      LR3  = 3'd7
   } state_t;

   logic [CW-1:0] cnt;
   logic          tick;
   state_t        state;
   state_t        state_nx;
   logic [5:0]    lamps;

   // Free-running; a divider of 1 keeps cnt at 0 so tick stays high.
   assign tick = (cnt == LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else if (tick) begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = IDLE;
      case (state)
         IDLE: begin
            if (bus.haz || (bus.left && bus.right)) begin
               state_nx = LR3;
            end else if (bus.left) begin
               state_nx = L1;
            end else if (bus.right) begin
               state_nx = R1;
            end else begin
               state_nx = IDLE;
            end
         end
         L1:      state_nx = bus.haz ? LR3 : L2;
         L2:      state_nx = bus.haz ? LR3 : L3;
         L3:      state_nx = IDLE;
         R1:      state_nx = bus.haz ? LR3 : R2;
         R2:      state_nx = bus.haz ? LR3 : R3;
         R3:      state_nx = IDLE;
         LR3:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Bit order: {LC, LB, LA, RA, RB, RC}
   always_comb begin
      lamps = '0;
      case (state)
         L1:      lamps = 6'b001_000;
         L2:      lamps = 6'b011_000;
         L3:      lamps = 6'b111_000;
         R1:      lamps = 6'b000_100;
         R2:      lamps = 6'b000_110;
         R3:      lamps = 6'b000_111;
         LR3:     lamps = 6'b111_111;
         default: lamps = '0;
      endcase
   end

   assign bus.LC = lamps[5];
   assign bus.LB = lamps[4];
   assign bus.LA = lamps[3];
   assign bus.RA = lamps[2];
   assign bus.RB = lamps[1];
   assign bus.RC = lamps[0];

endmodule

// File: tb/tb_thunderbird_seq.sv
// Scoreboard bench for thunderbird_seq: a TICK_DIV=4 and a TICK_DIV=1 instance share stimulus,
// and a mode/step reference model predicts both lamp vectors every cycle.
module tb_thunderbird_seq;

   logic clk;
   logic reset;

   thunderbird_seq_if bus4();
   thunderbird_seq_if bus1();

   thunderbird_seq #(.TICK_DIV(4)) dut4 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus4.slave)
   );

   thunderbird_seq #(.TICK_DIV(1)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1.slave)
   );

   typedef struct packed {
      logic [5:0] e4;
      logic [5:0] e1;
   } exp_t;

   exp_t q[$];

   int unsigned checks = 0;
   int unsigned errors = 0;

   // Reference model: mode 0=off, 1=left sweep, 2=right sweep, 3=hazard flash; step counts lit lamps.
   int unsigned divs  [2] = '{4, 1};
   int unsigned phase [2];
   int unsigned mode  [2];
   int unsigned stp   [2];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [5:0] pat(input int unsigned m, input int unsigned s);
      logic [5:0] p;
      p = 6'b000_000;
      case (m)
         1: p = {s >= 3, s >= 2, s >= 1, 3'b000};
         2: p = {3'b000, s >= 1, s >= 2, s >= 3};
         3: p = 6'b111_111;
         default: p = 6'b000_000;
      endcase
      return p;
   endfunction

   task automatic model_step(input int k, input logic rst, input logic l, input logic r,
                             input logic h);
      if (rst) begin
         phase[k] = 0;
         mode[k]  = 0;
         stp[k]   = 0;
      end else begin
         if (phase[k] == divs[k] - 1) begin
            if (mode[k] == 0) begin
               if (h || (l && r)) begin
                  mode[k] = 3;
               end else if (l) begin
                  mode[k] = 1;
                  stp[k]  = 1;
               end else if (r) begin
                  mode[k] = 2;
                  stp[k]  = 1;
               end
            end else if (mode[k] == 3) begin
               mode[k] = 0;
            end else if (stp[k] == 3) begin
               mode[k] = 0;
            end else if (h) begin
               mode[k] = 3;
            end else begin
               stp[k] = stp[k] + 1;
            end
         end
         phase[k] = (phase[k] + 1) % divs[k];
      end
   endtask

   task automatic cyc(input logic rst, input logic l, input logic r, input logic h);
      exp_t e;
      reset      = rst;
      bus4.left  = l;
      bus4.right = r;
      bus4.haz   = h;
      bus1.left  = l;
      bus1.right = r;
      bus1.haz   = h;
      model_step(0, rst, l, r, h);
      model_step(1, rst, l, r, h);
      e.e4 = pat(mode[0], stp[0]);
      e.e1 = pat(mode[1], stp[1]);
      q.push_back(e);
      @(posedge clk);
      #2;
   endtask

   task automatic hold(input int n, input logic rst, input logic l, input logic r, input logic h);
      for (int i = 0; i < n; i++) cyc(rst, l, r, h);
   endtask

   // Monitor: the lamps are valid every cycle, so one expectation is consumed after each edge.
   initial begin
      exp_t       e;
      logic [5:0] a4;
      logic [5:0] a1;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() != 0) begin
            e  = q.pop_front();
            a4 = {bus4.LC, bus4.LB, bus4.LA, bus4.RA, bus4.RB, bus4.RC};
            a1 = {bus1.LC, bus1.LB, bus1.LA, bus1.RA, bus1.RB, bus1.RC};
            checks = checks + 1;
            if (a4 !== e.e4) begin
               errors = errors + 1;
               $display("FAIL lamps_div4 t=%0t got %b expected %b", $time, a4, e.e4);
            end
            checks = checks + 1;
            if (a1 !== e.e1) begin
               errors = errors + 1;
               $display("FAIL lamps_div1 t=%0t got %b expected %b", $time, a1, e.e1);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog t=%0t got timeout expected completion", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic l;
      logic r;
      logic h;
      logic rst;
      int   n;

      // Reset, then idle
      hold(2, 1'b1, 1'b0, 1'b0, 1'b0);
      hold(20, 1'b0, 1'b0, 1'b0, 1'b0);

      // Held left from reset release
      hold(2, 1'b1, 1'b0, 1'b0, 1'b0);
      hold(36, 1'b0, 1'b1, 1'b0, 1'b0);

      // Right sweep aborted by hazard once at R2, hazard then held
      hold(2, 1'b1, 1'b0, 1'b0, 1'b0);
      hold(8, 1'b0, 1'b0, 1'b1, 1'b0);
      hold(20, 1'b0, 1'b0, 1'b1, 1'b1);
      hold(8, 1'b0, 1'b0, 1'b0, 1'b0);

      // Simultaneous left and right from idle
      hold(2, 1'b1, 1'b0, 1'b0, 1'b0);
      hold(12, 1'b0, 1'b1, 1'b1, 1'b0);
      hold(8, 1'b0, 1'b0, 1'b0, 1'b0);

      // Between-tick pulse at cnt=1, then left held through one tick and dropped
      hold(2, 1'b1, 1'b0, 1'b0, 1'b0);
      hold(1, 1'b0, 1'b0, 1'b0, 1'b0);
      hold(1, 1'b0, 1'b1, 1'b0, 1'b0);
      hold(6, 1'b0, 1'b0, 1'b0, 1'b0);
      hold(4, 1'b0, 1'b1, 1'b0, 1'b0);
      hold(20, 1'b0, 1'b0, 1'b0, 1'b0);

      // Right requested during a left sweep is ignored
      hold(4, 1'b0, 1'b1, 1'b0, 1'b0);
      hold(16, 1'b0, 1'b0, 1'b1, 1'b0);

      // Reset while in L3
      hold(2, 1'b1, 1'b0, 1'b0, 1'b0);
      hold(14, 1'b0, 1'b1, 1'b0, 1'b0);
      hold(1, 1'b1, 1'b1, 1'b0, 1'b0);
      hold(10, 1'b0, 1'b0, 1'b0, 1'b0);

      // Randomised runs of held inputs with occasional reset
      for (int i = 0; i < 300; i++) begin
         l   = ($urandom_range(0, 2) == 0);
         r   = ($urandom_range(0, 2) == 0);
         h   = ($urandom_range(0, 5) == 0);
         rst = ($urandom_range(0, 40) == 0);
         n   = int'($urandom_range(1, 12));
         hold(n, rst, l, r, h);
      end

      hold(2, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #3;
      checks = checks + 1;
      if (q.size() != 0) begin
         errors = errors + 1;
         $display("FAIL queue_drain got %0d pending expected 0", q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
